// File: rtl/iq_sync_fifo.sv
// Synchronous FIFO for paired I/Q samples.
// Each entry holds one complete sample: I in the upper half and Q in the lower half.
// Because I and Q share one entry, a read can never combine I and Q from different writes.
// The read and write pointers carry an extra wrap bit, so all DEPTH slots are usable.
// The occupancy flags are registered from the next-state level.
// As a result they always agree with level_o and never depend combinationally on the inputs.
module iq_sync_fifo #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16,
   parameter int AFULL_TH   = (1 << ADDR_WIDTH) - 4,
   parameter int AEMPTY_TH  = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    wr_en_i,
   input  logic [2*DATA_WIDTH-1:0] wr_data_i,
   input  logic                    rd_en_i,
   output logic [2*DATA_WIDTH-1:0] rd_data_o,
   output logic                    rd_valid_o,
   output logic                    full_o,
   output logic                    empty_o,
   output logic                    almost_full_o,
   output logic                    almost_empty_o,
   output logic [ADDR_WIDTH:0]     level_o,
   input  logic                    clear_flags_i,
   output logic                    overflow_o,
   output logic                    underflow_o,
   output logic [15:0]             drop_cnt_o
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int EW    = 2 * DATA_WIDTH;

   localparam logic [ADDR_WIDTH:0] LVL_DEPTH  = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] LVL_AFULL  = (ADDR_WIDTH+1)'(AFULL_TH);
   localparam logic [ADDR_WIDTH:0] LVL_AEMPTY = (ADDR_WIDTH+1)'(AEMPTY_TH);
   localparam logic [ADDR_WIDTH:0] LVL_ZERO   = '0;
   localparam logic [ADDR_WIDTH:0] ONE        = (ADDR_WIDTH+1)'(1);

   logic [EW-1:0]       mem [DEPTH];

   logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0] level_q, level_d;
   logic                full_q, empty_q, afull_q, aempty_q;
   logic [EW-1:0]       rd_data_q, rd_data_d;
   logic                rd_valid_q, rd_valid_d;
   logic                overflow_q, overflow_d;
   logic                underflow_q, underflow_d;
   logic [15:0]         drop_cnt_q, drop_cnt_d;

   logic                rd_accept;
   logic                wr_accept;
   logic                drop_evt;
   logic                under_evt;

   // Accept/reject decisions use only registered flags.
   // A write may use the slot freed by a same-cycle read, but a write never feeds a read directly.
   always_comb begin
      rd_accept = rd_en_i & ~empty_q;
      wr_accept = wr_en_i & (~full_q | rd_accept);
      drop_evt  = wr_en_i & ~wr_accept;
      under_evt = rd_en_i & empty_q;
   end

   // Next-state for pointers, level, read port and sticky error state.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      rd_data_d   = rd_data_q;
      rd_valid_d  = 1'b0;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      drop_cnt_d  = drop_cnt_q;

      if (wr_accept) begin
         wr_ptr_d = wr_ptr_q + ONE;
      end
      if (rd_accept) begin
         rd_ptr_d   = rd_ptr_q + ONE;
         rd_data_d  = mem[rd_ptr_q[ADDR_WIDTH-1:0]];
         rd_valid_d = 1'b1;
      end

      if (wr_accept && !rd_accept) begin
         level_d = level_q + ONE;
      end else if (rd_accept && !wr_accept) begin
         level_d = level_q - ONE;
      end

      // A clear wipes the old history, but an error event in the same cycle still registers.
      if (clear_flags_i) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
         drop_cnt_d  = 16'd0;
      end
      if (drop_evt) begin
         overflow_d = 1'b1;
         if (drop_cnt_d != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_d + 16'd1;
         end
      end
      if (under_evt) begin
         underflow_d = 1'b1;
      end
   end

   // Sample storage.
   // The storage has no reset; stale contents are unreachable once the pointers are cleared.
   always_ff @(posedge clk_i) begin
      if (wr_accept && !rst_i) begin
         mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data_i;
      end
   end

   // State registers.
   // The flags are registered from level_d so that they match the registered level.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         afull_q     <= 1'b0;
         aempty_q    <= 1'b1;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         drop_cnt_q  <= 16'd0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         full_q      <= (level_d == LVL_DEPTH);
         empty_q     <= (level_d == LVL_ZERO);
         afull_q     <= (level_d >= LVL_AFULL);
         aempty_q    <= (level_d <= LVL_AEMPTY);
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   // Output mapping.
   always_comb begin
      rd_data_o      = rd_data_q;
      rd_valid_o     = rd_valid_q;
      full_o         = full_q;
      empty_o        = empty_q;
      almost_full_o  = afull_q;
      almost_empty_o = aempty_q;
      level_o        = level_q;
      overflow_o     = overflow_q;
      underflow_o    = underflow_q;
      drop_cnt_o     = drop_cnt_q;
   end

endmodule

// File: doc/iq_sync_fifo.md
IQ_SYNC_FIFO -- requirements
Module: iq_sync_fifo

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, log2 of depth; DEPTH = 2**ADDR_WIDTH entries.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, width of one I or Q component; an entry is 2*DATA_WIDTH bits.
REQ-003 SHALL have parameter AFULL_TH, default DEPTH-4, almost-full threshold in entries.
REQ-004 SHALL have parameter AEMPTY_TH, default 4, almost-empty threshold in entries.
REQ-005 SHALL use one clock and a synchronous active-high reset: clk_i and rst_i.
REQ-006 SHALL have these ports, clock and reset first:
- clk_i  in  1  single clock; all state changes on its rising edge.
- rst_i  in  1  synchronous active-high reset.
- wr_en_i  in  1  write request.
- wr_data_i  in  2*DATA_WIDTH  sample; I in [2*DW-1:DW], Q in [DW-1:0].
- rd_en_i  in  1  read request.
- rd_data_o  out  2*DATA_WIDTH  read sample, I upper, Q lower.
- rd_valid_o  out  1  rd_data_o carries a newly read sample this cycle.
- full_o  out  1  level == DEPTH.
- empty_o  out  1  level == 0.
- almost_full_o  out  1  level >= AFULL_TH.
- almost_empty_o  out  1  level <= AEMPTY_TH.
- level_o  out  ADDR_WIDTH+1  entries stored, 0..DEPTH.
- clear_flags_i  in  1  clears the sticky error flags and drop_cnt_o.
- overflow_o  out  1  sticky: a write was dropped.
- underflow_o  out  1  sticky: a read was rejected.
- drop_cnt_o  out  16  saturating count of dropped writes.

Function
REQ-007 SHALL use all DEPTH entries. Pointers SHALL be ADDR_WIDTH+1 bits wide, with a wrap bit, so no slot is sacrificed.
REQ-008 Write accept = wr_en_i & (!full_o | rd_accept). An accepted write SHALL store wr_data_i at wr_ptr and increment wr_ptr modulo 2*DEPTH.
REQ-009 Read accept = rd_en_i & !empty_o. There SHALL be no bypass: a write in the same cycle never satisfies a read from an empty FIFO.
REQ-010 An accepted read SHALL register mem[rd_ptr] onto rd_data_o and assert rd_valid_o in the following cycle (1-cycle read latency), and SHALL increment rd_ptr.
REQ-011 rd_valid_o SHALL be a one-cycle pulse per accepted read. rd_data_o SHALL hold its last value when no read is accepted.
REQ-012 level_o SHALL update on the same edge as the pointers:
- +1 on write only.
- -1 on read only.
- unchanged on both or neither.
REQ-013 full_o, empty_o, almost_full_o and almost_empty_o SHALL be registered and always consistent with the registered level_o. They SHALL have no combinational path from inputs.
REQ-014 Simultaneous read and write while full SHALL accept both; level stays DEPTH and overflow_o does not set.
REQ-015 Simultaneous read and write while empty SHALL accept the write only and reject the read, which sets underflow_o; level becomes 1.
REQ-016 A write while full with no accepted read SHALL be dropped:
- memory and pointers unchanged.
- overflow_o set.
- drop_cnt_o incremented, saturating at 16'hFFFF.
REQ-017 A read while empty SHALL be ignored: rd_valid_o stays 0, rd_data_o is held, underflow_o is set.
REQ-018 clear_flags_i SHALL clear overflow_o, underflow_o and drop_cnt_o on the next edge. If an error event occurs in the same cycle, the event wins: the flag reads 1 and drop_cnt_o reads 1.
REQ-019 Pointer wrap-around SHALL be seamless. Ordering SHALL be strict FIFO across any number of wraps.
REQ-020 I and Q SHALL stay paired. No sample may ever have its I and Q taken from different entries.

Reset
REQ-021 While rst_i is high at a rising edge, the block SHALL clear:
- pointers and level_o to 0.
- empty_o = 1 and almost_empty_o = 1.
- full_o = 0 and almost_full_o = 0.
- rd_valid_o = 0 and rd_data_o = 0.
- overflow_o = 0, underflow_o = 0, drop_cnt_o = 0.
REQ-022 Reset SHALL override concurrent wr_en_i, rd_en_i and clear_flags_i. Reset mid-operation SHALL discard all stored data. Memory contents need not be cleared.

Verification
REQ-023 Fill/drain (ADDR_WIDTH=3): write 8 samples 0x00010002..0x00080009 -> full_o=1, level_o=8, almost_full_o=1. Then read 8 -> the data returns in order, 1 cycle after each rd_en_i, ending with empty_o=1.
REQ-024 Overflow: with the FIFO full, write 3 more samples -> level_o stays 8, overflow_o=1, drop_cnt_o=3. clear_flags_i -> both return to 0 next cycle.
REQ-025 Full with simultaneous read and write for 20 cycles -> level_o stays 8, no overflow, output sequence continuous across pointer wrap.
REQ-026 Empty with simultaneous read and write -> rd_valid_o=0, underflow_o=1, level_o=1. The next read returns the written sample.
REQ-027 Assert rst_i with level_o=5 while wr_en_i=1 -> the next cycle shows level_o=0, empty_o=1, rd_valid_o=0 and all flags 0.
REQ-028 Random bench against a reference queue model, 10k cycles, random enables -> zero mismatches, and level_o always equals the model count.
